commit_monitor: RTL

//  Synthesizable retirement monitor on the ROB commit ports of the N-way core.

---
 rtl/commit_monitor_pkg.sv | 30 +++
 rtl/commit_monitor_if.sv | 17 +
 rtl/commit_monitor_trace_buf.sv | 44 ++++
 rtl/commit_monitor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/commit_monitor_pkg.sv
// Shared types for the ROB retirement monitor: exception codes, FSM states, halt causes.
package commit_monitor_pkg;

  typedef enum logic [3:0] {
    INST_ADDR_MISALIGN  = 4'h0,
    INST_ACCESS_FAULT   = 4'h1,
    ILLEGAL_INST        = 4'h2,
    BREAKPOINT          = 4'h3,
    LOAD_ADDR_MISALIGN  = 4'h4,
    LOAD_ACCESS_FAULT   = 4'h5,
    STORE_ADDR_MISALIGN = 4'h6,
    STORE_ACCESS_FAULT  = 4'h7,
    ENV_CALL_U          = 4'h8,
    ENV_CALL_S          = 4'h9,
    NO_ERROR            = 4'ha,
    ENV_CALL_M          = 4'hb,
    INST_PAGE_FAULT     = 4'hc,
    LOAD_PAGE_FAULT     = 4'hd,
    HALTED_ON_WFI       = 4'he,
    STORE_PAGE_FAULT    = 4'hf
  } EXCEPTION_CODE;

  typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_DRAIN, MS_HALTED} MON_STATE;
  typedef enum logic [1:0] {HC_NONE, HC_ERROR, HC_WDOG, HC_EXT} HALT_CAUSE;

  localparam int NUM_EXC = 16;
  localparam logic [NUM_EXC-1:0] DEFAULT_ERR_IGNORE =
    (16'd1 << NO_ERROR) | (16'd1 << LOAD_ACCESS_FAULT);

endpackage

// File: rtl/commit_monitor_if.sv
// ROB commit-port bundle observed by the retirement monitor.
interface commit_monitor_if #(
  parameter int WAYS    = 2,
  parameter int XLEN    = 32,
  parameter int NUM_EVT = 4
);
  import commit_monitor_pkg::*;

  logic [WAYS-1:0]           commit_valid;
  logic [WAYS-1:0][XLEN-1:0] commit_pc;
  EXCEPTION_CODE             error_status;
  logic [NUM_EVT-1:0]        evt_in;

  modport master (output commit_valid, commit_pc, error_status, evt_in);
  modport slave  (input  commit_valid, commit_pc, error_status, evt_in);

endinterface

// File: rtl/commit_monitor_trace_buf.sv
// Circular buffer of the most recently retired PCs; valid ways are packed oldest-first.
module commit_trace_buf #(
  parameter int WAYS        = 2,
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 16,
  localparam int PTR_W      = $clog2(TRACE_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [WAYS-1:0]           valid_i,
  input  logic [WAYS-1:0][XLEN-1:0] pc_i,
  input  logic [PTR_W-1:0]          rd_idx_i,
  output logic [XLEN-1:0]           rd_pc_o
);

  logic [TRACE_DEPTH-1:0][XLEN-1:0] mem_q;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [WAYS-1:0][PTR_W-1:0]       slot;

  // Each valid way takes the next free slot; the running pointer doubles as the slot rank.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    slot     = '0;
    for (int w = 0; w < WAYS; w++) begin
      slot[w] = wr_ptr_d;
      if (we_i && valid_i[w]) wr_ptr_d = wr_ptr_d + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      for (int w = 0; w < WAYS; w++)
        if (we_i && valid_i[w]) mem_q[slot[w]] <= pc_i[w];
    end
  end

  assign rd_pc_o = mem_q[wr_ptr_q - PTR_W'(1) - rd_idx_i];

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: saturating perf counters, watchdog, error halt and dcache drain handshake.
// Optional PC trace buffer enabled with `define COMMIT_TRACE_EN.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int                 WAYS            = 2,
  parameter int                 XLEN            = 32,
  parameter int                 CNT_W           = 32,
  parameter int                 NUM_EVT         = 4,
  parameter int                 WDOG_W          = 16,
  parameter logic [NUM_EXC-1:0] ERR_IGNORE_MASK = DEFAULT_ERR_IGNORE,
  parameter int                 TRACE_DEPTH     = 16,
  localparam int                IDX_W           = $clog2(TRACE_DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           clear,
  input  logic                           halt_req,
  commit_monitor_if.slave                cif,
  input  logic [WDOG_W-1:0]              wdog_limit,
  input  logic                           flush_ack,
  output logic                           flush_req,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               instr_cnt,
  output logic [NUM_EVT-1:0][CNT_W-1:0]  evt_cnt,
  output logic [XLEN-1:0]                last_pc,
  output MON_STATE                       state,
  output HALT_CAUSE                      halt_cause,
  output logic                           halted,
  input  logic [IDX_W-1:0]               trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WAYS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WAYS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  MON_STATE                      state_q, state_d;
  HALT_CAUSE                     cause_q, cause_d;
  logic                          flush_q, flush_d;
  logic [CNT_W-1:0]              cyc_q, cyc_d, ins_q, ins_d;
  logic [NUM_EVT-1:0][CNT_W-1:0] evt_q, evt_d;
  logic [WDOG_W-1:0]             idle_q, idle_d;
  logic [XLEN-1:0]               last_pc_q, last_pc_d;

  logic in_run, any_commit, err_hit, wdog_hit, clear_en;

  assign in_run     = (state_q == MS_RUN);
  assign any_commit = |cif.commit_valid;
  assign err_hit    = ~ERR_IGNORE_MASK[cif.error_status];
  // A retirement in the match cycle proves forward progress, so it vetoes the watchdog.
  assign wdog_hit   = (wdog_limit != '0) && (idle_q == wdog_limit) && !any_commit;
  assign clear_en   = clear && (state_q == MS_IDLE || in_run);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    flush_d = flush_q;
    unique case (state_q)
      MS_IDLE:  if (start) state_d = MS_RUN;
      MS_RUN: begin
        if (err_hit || wdog_hit || halt_req) begin
          state_d = MS_DRAIN;
          flush_d = 1'b1;
          cause_d = err_hit ? HC_ERROR : (wdog_hit ? HC_WDOG : HC_EXT);
        end
      end
      MS_DRAIN: begin
        if (flush_ack) begin
          state_d = MS_HALTED;
          flush_d = 1'b0;
        end
      end
      MS_HALTED: state_d = MS_HALTED;
      default:   state_d = MS_IDLE;
    endcase
  end

  always_comb begin
    cyc_d     = cyc_q;
    ins_d     = ins_q;
    evt_d     = evt_q;
    idle_d    = idle_q;
    last_pc_d = last_pc_q;
    if (clear_en) begin
      cyc_d  = '0;
      ins_d  = '0;
      evt_d  = '0;
      idle_d = '0;
    end else if (in_run) begin
      cyc_d = sat_add(cyc_q, CNT_W'(1));
      ins_d = sat_add(ins_q, popcount(cif.commit_valid));
      for (int i = 0; i < NUM_EVT; i++)
        evt_d[i] = sat_add(evt_q[i], CNT_W'(cif.evt_in[i]));
      if (any_commit)         idle_d = '0;
      else if (idle_q != '1)  idle_d = idle_q + WDOG_W'(1);
    end
    if (in_run)
      for (int w = 0; w < WAYS; w++)
        if (cif.commit_valid[w]) last_pc_d = cif.commit_pc[w];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MS_IDLE;
      cause_q   <= HC_NONE;
      flush_q   <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
      evt_q     <= '0;
      idle_q    <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      flush_q   <= flush_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
      evt_q     <= evt_d;
      idle_q    <= idle_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign state      = state_q;
  assign halt_cause = cause_q;
  assign flush_req  = flush_q;
  assign halted     = (state_q == MS_HALTED);
  assign cycle_cnt  = cyc_q;
  assign instr_cnt  = ins_q;
  assign evt_cnt    = evt_q;
  assign last_pc    = last_pc_q;

`ifdef COMMIT_TRACE_EN
  commit_trace_buf #(
    .WAYS       (WAYS),
    .XLEN       (XLEN),
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .we_i    (in_run),
    .valid_i (cif.commit_valid),
    .pc_i    (cif.commit_pc),
    .rd_idx_i(trace_rd_idx),
    .rd_pc_o (trace_rd_pc)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_rd_idx;
  assign trace_rd_pc      = '0;
`endif

endmodule
